// File: rtl/cic_int.sv
// K-stage CIC interpolator by R: low-rate comb section, zero-stuffing, full-rate
// integrators, round-half-up and saturation into a registered output.
module cic_int #(
    parameter int Win  = 16,
    parameter int Wout = 18,
    parameter int R    = 2000,
    parameter int K    = 2,
    parameter int Ng   = 11
) (
    input  logic            clk,
    input  logic            ic_rst,
    input  logic [Win-1:0]  id_data,
    input  logic            ic_val_data,
    output logic            oc_rdy_data,
    output logic [Wout-1:0] od_data,
    output logic            oc_val_data,
    output logic            oc_unf,
    output logic            oc_ovf
);
    localparam int CW = Win + K;
    localparam int IW = Win + Ng;
    localparam int XW = IW + 1;
    localparam int D  = IW - Wout;
    localparam int PW = $clog2(R);
    localparam logic [PW-1:0]        PH_LAST = PW'(R - 1);
    localparam logic signed [XW-1:0] RND     = XW'((64'sd1 <<< D) >>> 1);
    localparam logic signed [XW-1:0] SAT_HI  = XW'((64'sd1 <<< (Wout - 1)) - 64'sd1);
    localparam logic signed [XW-1:0] SAT_LO  = XW'(-(64'sd1 <<< (Wout - 1)));

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic signed [Win-1:0] sample_q, sample_d;
    logic [K-1:0]          ev_q, ev_d;
    logic signed [CW-1:0]  dly_q [K];
    logic signed [CW-1:0]  dly_d [K];
    logic signed [CW-1:0]  comb_q [K];
    logic signed [CW-1:0]  comb_d [K];
    logic signed [IW-1:0]  integ_q [K];
    logic signed [IW-1:0]  integ_d [K];
    logic [2*K-1:0]        live_q, live_d;
    logic                  val_q, val_d;
    logic [Wout-1:0]       od_q, od_d;

    logic                  run_s, last_s, inj_s;
    logic signed [CW-1:0]  cin_s [K];
    logic signed [IW-1:0]  isrc_s [K];
    logic signed [XW-1:0]  rnd_s, shr_s;

    assign run_s  = (state_q == S_RUN);
    assign last_s = run_s && (phase_q == PH_LAST);
    assign inj_s  = run_s && (phase_q == {PW{1'b0}});

    assign oc_rdy_data = !ic_rst && (!run_s || last_s);
    assign oc_unf      = !ic_rst && last_s && !ic_val_data;
    assign oc_ovf      = !ic_rst && run_s && !last_s && ic_val_data;
    assign od_data     = od_q;
    assign oc_val_data = val_q;

    // Request/accept sequencing; a missed request injects a zero sample.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        sample_d = sample_q;
        case (state_q)
            S_IDLE: begin
                if (ic_val_data) begin
                    state_d  = S_RUN;
                    phase_d  = {PW{1'b0}};
                    sample_d = $signed(id_data);
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    phase_d  = {PW{1'b0}};
                    sample_d = ic_val_data ? $signed(id_data) : {Win{1'b0}};
                end else begin
                    phase_d  = phase_q + PW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stage inputs: each comb feeds the next, integrators chain from the zero-stuffed comb output.
    always_comb begin
        cin_s[0]  = CW'(sample_q);
        isrc_s[0] = ev_q[K-1] ? IW'(comb_q[K-1]) : {IW{1'b0}};
        for (int j = 1; j < K; j++) begin
            cin_s[j]  = comb_q[j-1];
            isrc_s[j] = integ_q[j-1];
        end
    end

    // ev_d[j] marks the cycle comb stage j sees the injection travelling down the chain.
    always_comb begin
        ev_d    = ev_q;
        dly_d   = dly_q;
        comb_d  = comb_q;
        integ_d = integ_q;
        live_d  = live_q;
        ev_d[0]   = inj_s;
        live_d[0] = run_s;
        for (int j = 1; j < K; j++) begin
            ev_d[j] = ev_q[j-1];
        end
        for (int j = 1; j < 2 * K; j++) begin
            live_d[j] = live_q[j-1];
        end
        for (int j = 0; j < K; j++) begin
            if (ev_d[j]) begin
                comb_d[j] = cin_s[j] - dly_q[j];
                dly_d[j]  = cin_s[j];
            end else begin
                comb_d[j] = comb_q[j];
                dly_d[j]  = dly_q[j];
            end
            if (run_s) begin
                integ_d[j] = integ_q[j] + isrc_s[j];
            end else begin
                integ_d[j] = integ_q[j];
            end
        end
        val_d = val_q | live_q[2*K-1];
    end

    // Round half up on the dropped LSBs, then clamp to the output range.
    always_comb begin
        rnd_s = XW'(integ_q[K-1]) + RND;
        shr_s = rnd_s >>> D;
        if (shr_s > SAT_HI) begin
            od_d = Wout'(SAT_HI);
        end else if (shr_s < SAT_LO) begin
            od_d = Wout'(SAT_LO);
        end else begin
            od_d = Wout'(shr_s);
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (ic_rst) begin
            state_q  <= S_IDLE;
            phase_q  <= {PW{1'b0}};
            sample_q <= {Win{1'b0}};
            ev_q     <= {K{1'b0}};
            live_q   <= {(2*K){1'b0}};
            val_q    <= 1'b0;
            od_q     <= {Wout{1'b0}};
            for (int j = 0; j < K; j++) begin
                dly_q[j]   <= {CW{1'b0}};
                comb_q[j]  <= {CW{1'b0}};
                integ_q[j] <= {IW{1'b0}};
            end
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            sample_q <= sample_d;
            ev_q     <= ev_d;
            live_q   <= live_d;
            val_q    <= val_d;
            od_q     <= od_d;
            for (int j = 0; j < K; j++) begin
                dly_q[j]   <= dly_d[j];
                comb_q[j]  <= comb_d[j];
                integ_q[j] <= integ_d[j];
            end
        end
    end
endmodule

// File: tb/tb_cic_int.sv
// Directed bench for cic_int: a default instance (R=2000) and a small one (R=4, Ng=2)
// checked every cycle against a convolution model of the CIC impulse response.
module tb_cic_int;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v0, v1;
    logic [15:0] d0, d1;
    logic        rdy0, val0, unf0, ovf0, rdy1, val1, unf1, ovf1;
    logic [17:0] od0, od1;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    cic_int dut0 (
        .clk(clk), .ic_rst(rst), .id_data(d0), .ic_val_data(v0),
        .oc_rdy_data(rdy0), .od_data(od0), .oc_val_data(val0),
        .oc_unf(unf0), .oc_ovf(ovf0)
    );

    cic_int #(.Win(16), .Wout(18), .R(4), .K(2), .Ng(2)) dut1 (
        .clk(clk), .ic_rst(rst), .id_data(d1), .ic_val_data(v1),
        .oc_rdy_data(rdy1), .od_data(od1), .oc_val_data(val1),
        .oc_unf(unf1), .oc_ovf(ovf1)
    );

    localparam int KK = 2;
    int RR [2] = '{2000, 4};
    int DD [2] = '{9, 0};

    longint h [0:1][0:4095];
    bit     run_m [2];
    longint t0_m [2];
    longint vst_m [2];
    longint it_m [2][4];
    longint ix_m [2][4];
    int     ni_m [2];
    bit     chk_on = 1'b0;
    int     rdy_cnt0 = 0;
    int     unf_cnt0 = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // Impulse response of K cascaded length-R moving sums.
    task automatic build_h(input int i);
        longint a [0:4095];
        longint b [0:4095];
        longint s;
        for (int k = 0; k < 4096; k++) a[k] = (k == 0) ? 1 : 0;
        repeat (KK) begin
            s = 0;
            for (int k = 0; k < 4096; k++) begin
                s += a[k];
                if (k >= RR[i]) s -= a[k - RR[i]];
                b[k] = s;
            end
            a = b;
        end
        for (int k = 0; k < 4096; k++) h[i][k] = a[k];
    endtask

    task automatic add_inj(input int i, input longint t, input longint x);
        it_m[i][ni_m[i] % 4] = t;
        ix_m[i][ni_m[i] % 4] = x;
        ni_m[i]++;
    endtask

    function automatic longint exp_od(input int i, input longint n);
        longint acc = 0;
        longint k;
        int cnt = (ni_m[i] < 4) ? ni_m[i] : 4;
        for (int e = 0; e < cnt; e++) begin
            k = n - it_m[i][e] - 5;
            if (k >= 0 && k < 4096) acc += ix_m[i][e] * h[i][k];
        end
        if (DD[i] > 0) acc = (acc + (longint'(1) <<< (DD[i] - 1))) >>> DD[i];
        if (acc > 131071) acc = 131071;
        else if (acc < -131072) acc = -131072;
        return acc;
    endfunction

    task automatic model(input int i, input logic rdy, input logic unf, input logic ovf,
                         input logic val, input logic [17:0] od, input logic vin,
                         input logic [15:0] din);
        longint n = cyc;
        bit e_rdy, e_unf, e_ovf, e_val;
        e_rdy = !rst && (!run_m[i] || (n > t0_m[i] && ((n - t0_m[i]) % RR[i]) == 0));
        e_unf = e_rdy && run_m[i] && !vin;
        e_ovf = !rst && run_m[i] && !e_rdy && vin;
        e_val = (vst_m[i] >= 0) && (n >= vst_m[i]);
        check($sformatf("rdy%0d", i), longint'(rdy), longint'(e_rdy));
        check($sformatf("unf%0d", i), longint'(unf), longint'(e_unf));
        check($sformatf("ovf%0d", i), longint'(ovf), longint'(e_ovf));
        check($sformatf("val%0d", i), longint'(val), longint'(e_val));
        check($sformatf("od%0d", i), longint'($signed(od)), exp_od(i, n));
        if (rst) begin
            run_m[i] = 1'b0;
            ni_m[i]  = 0;
            vst_m[i] = -1;
        end else if (!run_m[i] && vin) begin
            run_m[i] = 1'b1;
            t0_m[i]  = n;
            vst_m[i] = n + 6;
            add_inj(i, n + 1, longint'($signed(din)));
        end else if (run_m[i] && e_rdy) begin
            add_inj(i, n + 1, vin ? longint'($signed(din)) : 0);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            model(0, rdy0, unf0, ovf0, val0, od0, v0, d0);
            model(1, rdy1, unf1, ovf1, val1, od1, v1, d1);
            if (rdy0) rdy_cnt0++;
            if (unf0) unf_cnt0++;
        end
    end

    task automatic to_cycle(input longint c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic impulse_check(input longint a);
        int seq [9] = '{0, 1, 2, 3, 4, 3, 2, 1, 0};
        for (int k = 0; k < 9; k++) begin
            to_cycle(a + 5 + k);
            @(negedge clk);
            check($sformatf("impulse_k%0d", k + 5), longint'($signed(od1)), longint'(seq[k]));
        end
    endtask

    longint a, cu, x, b;
    int r_a;

    initial begin
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = 16'h0; d1 = 16'h0;
        for (int i = 0; i < 2; i++) begin
            build_h(i);
            run_m[i] = 1'b0; ni_m[i] = 0; vst_m[i] = -1; t0_m[i] = 0;
        end
        @(posedge clk); #1;
        chk_on = 1'b1;

        to_cycle(3);
        @(negedge clk);
        check("rst_od0", longint'(od0), 0);
        check("rst_val0", longint'(val0), 0);
        check("rst_rdy0", longint'(rdy0), 0);
        check("rst_od1", longint'(od1), 0);
        check("rst_val1", longint'(val1), 0);
        check("rst_rdy1", longint'(rdy1), 0);
        to_cycle(4);
        rst = 1'b0;
        to_cycle(8);
        @(negedge clk);
        check("idle_rdy0", longint'(rdy0), 1);
        check("idle_val0", longint'(val0), 0);

        to_cycle(10);
        a = cyc;
        v0 = 1'b1; d0 = 16'h4000;
        v1 = 1'b1; d1 = 16'd1;
        to_cycle(a + 1);
        d1 = 16'd0;
        r_a = rdy_cnt0;
        impulse_check(a);

        to_cycle(a + 2001);
        check("rdy_per_R", longint'(rdy_cnt0 - r_a), 1);
        to_cycle(a + 4100);
        @(negedge clk);
        check("dc_od", longint'($signed(od0)), 64000);
        check("dc_od_hex", longint'(od0), longint'(18'h0FA00));

        cu = a + 3 * 2000;
        to_cycle(cu);
        check("dc_no_unf", longint'(unf_cnt0), 0);
        v0 = 1'b0;
        @(negedge clk);
        check("unf_pulse", longint'(unf0), 1);
        check("unf_rdy", longint'(rdy0), 1);
        to_cycle(cu + 1);
        v0 = 1'b1;
        to_cycle(cu + 2005);
        @(negedge clk);
        check("unf_dip_od", longint'($signed(od0)), 0);
        check("unf_val", longint'(val0), 1);

        to_cycle(cu + 2100);
        d0 = 16'h8000;
        to_cycle(cu + 6200);
        @(negedge clk);
        check("neg_od", longint'($signed(od0)), -128000);
        check("neg_od_hex", longint'(od0), longint'(18'h20C00));
        check("neg_ovf", longint'(ovf0), 1);
        check("neg_rdy", longint'(rdy0), 0);

        x = cu + 6300;
        to_cycle(x);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rdy0", longint'(rdy0), 0);
        check("mid_rst_rdy1", longint'(rdy1), 0);
        check("mid_rst_ovf0", longint'(ovf0), 0);
        to_cycle(x + 1);
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0; d1 = 16'd0;
        @(negedge clk);
        check("post_rst_od0", longint'(od0), 0);
        check("post_rst_val0", longint'(val0), 0);
        check("post_rst_od1", longint'(od1), 0);
        check("post_rst_val1", longint'(val1), 0);
        check("post_rst_rdy1", longint'(rdy1), 1);

        to_cycle(x + 5);
        b = cyc;
        v1 = 1'b1; d1 = 16'd1;
        to_cycle(b + 1);
        d1 = 16'd0;
        impulse_check(b);
        check("idle_after_rst_val0", longint'(val0), 0);

        to_cycle(b + 20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
